// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode unit: FSM state encoding,
// supported opcode/funct values, datapath widths and a sign-extend helper.
package fetch_decode_unit_pkg;

  localparam int unsigned XLEN   = 32;  // datapath / instruction width
  localparam int unsigned RIDX_W = 5;   // register index width
  localparam int unsigned PC_W   = 3;   // instruction address width

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_decode_unit_regfile.sv
// fd_regfile: register file with r0 hardwired to zero.
// Ports:
//   clk             clock
//   clr             synchronous clear of every register
//   ra, rb          combinational read indices -> rd_a, rd_b
//   dbg_addr        combinational debug read index -> dbg_data
//   we, wa, wd      synchronous write port (writes to index 0 are dropped)
module fd_regfile
  import fetch_decode_unit_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   rd_a,
  output logic [XLEN-1:0]   rd_b,
  output logic [XLEN-1:0]   dbg_data,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] mem [NREG];

  // Index 0 and indices beyond the implemented depth read as zero.
  assign rd_a     = (ra == '0 || 32'(ra) >= NREG) ? '0 : mem[ra];
  assign rd_b     = (rb == '0 || 32'(rb) >= NREG) ? '0 : mem[rb];
  assign dbg_data = (dbg_addr == '0 || 32'(dbg_addr) >= NREG) ? '0 : mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0 && 32'(wa) < NREG) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: four-stage (FETCH, DECODE, EXEC, WB) multi-cycle core
// running PROG_LEN instructions (ADDIU, ADDU, SUBU) then halting.
// Ports:
//   clk       clock, all state on posedge
//   rst       synchronous active-high reset
//   run       fetch enable; low holds the unit in FETCH
//   counter   registered instruction address
//   instr     instruction word from memory (updated on negedge from counter)
//   dbg_addr  debug register read index
//   dbg_data  combinational debug read data
//   done      high while halted
//   illegal   sticky unsupported-instruction flag
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int unsigned PROG_LEN = 7,
  parameter int unsigned NREG     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   counter,
  input  logic [XLEN-1:0]   instr,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic              done,
  output logic              illegal
);

  state_t            state;
  logic [XLEN-1:0]   ir;
  logic [XLEN-1:0]   op_a, op_b, alu_q;
  logic              alu_sub;
  logic              dec_legal;
  logic [RIDX_W-1:0] wr_idx;
  logic [XLEN-1:0]   rs_data, rt_data;

  logic [5:0]        op, funct;
  logic [RIDX_W-1:0] rs, rt, rd;
  logic [15:0]       imm;
  logic              is_addiu, is_addu, is_subu;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  assign is_addiu = (op == OP_ADDIU);
  assign is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);

  fd_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .clr      (rst),
    .ra       (rs),
    .rb       (rt),
    .dbg_addr (dbg_addr),
    .rd_a     (rs_data),
    .rd_b     (rt_data),
    .dbg_data (dbg_data),
    .we       (state == S_WB && dec_legal && !rst),
    .wa       (wr_idx),
    .wd       (alu_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      counter   <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      alu_q     <= '0;
      alu_sub   <= 1'b0;
      dec_legal <= 1'b0;
      wr_idx    <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (run) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Operands and destination are captured here so EXEC/WB no
          // longer depend on the register file read ports.
          op_a      <= rs_data;
          op_b      <= is_addiu ? sign_ext16(imm) : rt_data;
          alu_sub   <= is_subu;
          dec_legal <= is_addiu | is_addu | is_subu;
          wr_idx    <= is_addiu ? rt : rd;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          alu_q <= alu_sub ? (op_a - op_b) : (op_a + op_b);
          if (!dec_legal) illegal <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          if (counter == PC_W'(PROG_LEN - 1)) begin
            done  <= 1'b1;
            state <= S_HALT;
          end else begin
            counter <= counter + 1'b1;
            state   <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  counter;
  logic [31:0] instr = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        done;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  logic [31:0] imem [8];

  fetch_decode_unit #(.PROG_LEN(7), .NREG(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .counter  (counter),
    .instr    (instr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory: updates on negedge from counter.
  always @(negedge clk) instr = imem[counter];

  task automatic load_main();
    imem[0] = 32'h2401002D; // addiu r1,r0,45
    imem[1] = 32'h2402FFEC; // addiu r2,r0,-20
    imem[2] = 32'h2403FFC4; // addiu r3,r0,-60
    imem[3] = 32'h2404001E; // addiu r4,r0,30
    imem[4] = 32'h00222821; // addu  r5,r1,r2
    imem[5] = 32'h00643021; // addu  r6,r3,r4
    imem[6] = 32'h00A62823; // subu  r5,r5,r6
    imem[7] = 32'h24000000; // addiu r0,r0,0
  endtask

  // Holds rst for two posedges, releases it 1 time unit after a posedge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    load_main();
    run = 1'b1;
    do_reset();
    checks++; if (counter !== 3'd0) begin failures++; $display("FAIL reset_counter got=%0d exp=0", counter); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL reset_r1 got=%h exp=0", dbg_data); end
  endtask

  task automatic test_program();
    logic [31:0] exp [7];
    exp = '{32'h0, 32'd45, 32'hFFFFFFEC, 32'hFFFFFFC4, 32'd30, 32'd55, 32'hFFFFFFE2};
    load_main();
    run = 1'b1;
    do_reset();
    // First WB of r1: posedge 4; dbg shows old value until then.
    dbg_addr = 5'd1;
    step(3);
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL wb_old_value got=%h exp=0", dbg_data); end
    step(1);
    checks++; if (dbg_data !== 32'd45) begin failures++; $display("FAIL wb_new_value got=%h exp=2d", dbg_data); end
    checks++; if (counter !== 3'd1) begin failures++; $display("FAIL counter_after_1 got=%0d exp=1", counter); end
    step(23);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
    step(1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_at_28 got=%b exp=1", done); end
    checks++; if (counter !== 3'd6) begin failures++; $display("FAIL halt_counter got=%0d exp=6", counter); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL prog_illegal got=%b exp=0", illegal); end
    for (int i = 0; i < 7; i++) begin
      dbg_addr = 5'(i); #1;
      checks++;
      if (dbg_data !== exp[i]) begin failures++; $display("FAIL prog_r%0d got=%h exp=%h", i, dbg_data, exp[i]); end
    end
    step(10);
    checks++; if (done !== 1'b1 || counter !== 3'd6) begin failures++; $display("FAIL halt_absorb done=%b counter=%0d exp done=1 counter=6", done, counter); end
  endtask

  task automatic test_halt_reset();
    // Still halted from the previous program.
    rst = 1'b1;
    step(1);
    dbg_addr = 5'd5; #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL halt_rst_done got=%b exp=0", done); end
    checks++; if (counter !== 3'd0) begin failures++; $display("FAIL halt_rst_counter got=%0d exp=0", counter); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL halt_rst_r5 got=%h exp=0", dbg_data); end
    rst = 1'b0;
  endtask

  task automatic test_stall();
    load_main();
    run = 1'b0;
    do_reset();
    step(10);
    checks++; if (counter !== 3'd0) begin failures++; $display("FAIL stall_counter got=%0d exp=0", counter); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL stall_r1 got=%h exp=0", dbg_data); end
    run = 1'b1;
    step(27);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stall_done_early got=%b exp=0", done); end
    step(1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done_at_38 got=%b exp=1", done); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'd55) begin failures++; $display("FAIL stall_r5 got=%h exp=37", dbg_data); end
  endtask

  task automatic test_r0_wrap();
    imem[0] = 32'h24000005; // addiu r0,r0,5
    imem[1] = 32'h24020001; // addiu r2,r0,1
    imem[2] = 32'h00021823; // subu  r3,r0,r2
    imem[3] = 32'h00622021; // addu  r4,r3,r2
    for (int i = 4; i < 8; i++) imem[i] = 32'h24000000;
    run = 1'b1;
    do_reset();
    step(4);
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL r0_write got=%h exp=0", dbg_data); end
    step(24);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", done); end
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL subu_wrap got=%h exp=ffffffff", dbg_data); end
    dbg_addr = 5'd4; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL addu_wrap got=%h exp=0", dbg_data); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL wrap_illegal got=%b exp=0", illegal); end
  endtask

  task automatic test_illegal();
    load_main();
    imem[2] = 32'hFC000000;
    run = 1'b1;
    do_reset();
    step(10); // instruction 2 now in EXEC
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_early got=%b exp=0", illegal); end
    step(1);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_set got=%b exp=1", illegal); end
    step(1);
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL illegal_r3 got=%h exp=0", dbg_data); end
    checks++; if (counter !== 3'd3) begin failures++; $display("FAIL illegal_seq got=%0d exp=3", counter); end
    step(16);
    checks++; if (done !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL illegal_end done=%b illegal=%b exp 1 1", done, illegal); end
    dbg_addr = 5'd6; #1;
    checks++; if (dbg_data !== 32'd30) begin failures++; $display("FAIL illegal_r6 got=%h exp=1e", dbg_data); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'hFFFFFFFB) begin failures++; $display("FAIL illegal_r5 got=%h exp=fffffffb", dbg_data); end
  endtask

  task automatic test_midreset();
    load_main();
    run = 1'b1;
    do_reset();
    step(18); // instruction at address 4 now in EXEC
    checks++; if (counter !== 3'd4) begin failures++; $display("FAIL mid_pre_counter got=%0d exp=4", counter); end
    rst = 1'b1;
    step(1);
    checks++; if (counter !== 3'd0) begin failures++; $display("FAIL mid_counter got=%0d exp=0", counter); end
    for (int i = 1; i < 7; i++) begin
      dbg_addr = 5'(i); #1;
      checks++;
      if (dbg_data !== 32'h0) begin failures++; $display("FAIL mid_clear_r%0d got=%h exp=0", i, dbg_data); end
    end
    rst = 1'b0;
    step(4); // survive a few more edges with no stale write-back
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL mid_no_partial_wb got=%h exp=0", dbg_data); end
    step(24);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mid_rerun_done got=%b exp=1", done); end
    checks++; if (dbg_data !== 32'd55) begin failures++; $display("FAIL mid_rerun_r5 got=%h exp=37", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_halt_reset();
    test_stall();
    test_r0_wrap();
    test_illegal();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
